onets_pl_btn_debounce: RTL and testbench

//  Input-side counterpart of the PL LED/PMOD blink outputs: samples N asynchronous

---
 rtl/onets_pkg.sv | 19 +
 rtl/onets_btn_chan.sv | 148 ++++++++++++++
 rtl/onets_pl_btn_debounce.sv | 40 ++++
 tb/tb_onets_pl_btn_debounce.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onets_pkg.sv
// Shared definitions for the PL push-button input path: debounce FSM states and
// fabric clock constants.
package onets_pkg;

  localparam int unsigned FCLK0_HZ = 125_000_000;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    PRESSED    = 3'd2,
    HELD       = 3'd3,
    RELEASE_DB = 3'd4
  } btn_state_e;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (FCLK0_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/onets_btn_chan.sv
// One push-button channel: 2-flop synchroniser, debounce/long-press FSM with a
// shared timer, registered event pulses and an 8-bit press counter.
module onets_btn_chan
  import onets_pkg::*;
#(
  parameter bit          ACT_LOW     = 1'b1,
  parameter int unsigned DB_CYCLES   = 1_250_000,
  parameter int unsigned LONG_CYCLES = 125_000_000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_i,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o,
  output logic [7:0] cnt_o
);

  if (DB_CYCLES < 2 || LONG_CYCLES < 2 ||
      longint'(LONG_CYCLES) > (longint'(1) << CNT_W) ||
      longint'(DB_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_param
    $error("onets_btn_chan: DB_CYCLES/LONG_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic             s1_q, s_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             from_held_q, from_held_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic [7:0]       cnt_q, cnt_d;

  // Normalise to 1 = pressed before the synchroniser so reset means "released".
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s_q  <= 1'b0;
    end else begin
      s1_q <= btn_i ^ ACT_LOW;
      s_q  <= s1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      from_held_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      from_held_q <= from_held_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + CNT_W'(1);
    from_held_d = from_held_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (s_q) state_d = PRESS_DB;
      end

      PRESS_DB: begin
        if (!s_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d = PRESSED;
          timer_d = '0;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end

      PRESSED: begin
        if (!s_q) begin
          state_d     = RELEASE_DB;
          timer_d     = '0;
          from_held_d = 1'b0;
        end else if (timer_q == LONG_LAST) begin
          state_d = HELD;
          timer_d = '0;
          long_d  = 1'b1;
        end
      end

      // Timer parked at zero: the long event already fired for this hold.
      HELD: begin
        timer_d = '0;
        if (!s_q) begin
          state_d     = RELEASE_DB;
          from_held_d = 1'b1;
        end
      end

      RELEASE_DB: begin
        if (s_q) begin
          state_d = from_held_q ? HELD : PRESSED;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d   = IDLE;
          timer_d   = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/onets_pl_btn_debounce.sv
// PL push-button front end: N independent debounced channels producing level,
// press/release/long-press pulses and per-button press counts.
module onets_pl_btn_debounce
  import onets_pkg::*;
#(
  parameter int unsigned N_BTN       = 2,
  parameter bit          BTN_ACT_LOW = 1'b1,
  parameter int unsigned DB_CYCLES   = ms_to_cycles(10),
  parameter int unsigned LONG_CYCLES = ms_to_cycles(1000),
  parameter int unsigned CNT_W       = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_BTN-1:0]   pl_btn,
  output logic [N_BTN-1:0]   btn_level,
  output logic [N_BTN-1:0]   btn_press,
  output logic [N_BTN-1:0]   btn_release,
  output logic [N_BTN-1:0]   btn_long,
  output logic [8*N_BTN-1:0] press_cnt
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    onets_btn_chan #(
      .ACT_LOW    (BTN_ACT_LOW),
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .btn_i    (pl_btn[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .long_o   (btn_long[i]),
      .cnt_o    (press_cnt[8*i +: 8])
    );
  end

endmodule

// File: tb/tb_onets_pl_btn_debounce.sv
// Self-checking bench: reference model of the debounce rules compared every cycle,
// a vector table, directed latency/corner sequences and random pad activity.
module tb_onets_pl_btn_debounce;

  localparam int DB   = 8;
  localparam int LONG = 32;
  localparam int LAT  = 2 + DB + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pl_btn;
  logic [1:0]  btn_level, btn_press, btn_release, btn_long;
  logic [15:0] press_cnt;

  int checks = 0;
  int passes = 0;

  onets_pl_btn_debounce #(
    .N_BTN      (2),
    .BTN_ACT_LOW(1'b1),
    .DB_CYCLES  (DB),
    .LONG_CYCLES(LONG),
    .CNT_W      (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pl_btn     (pl_btn),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .press_cnt  (press_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: run length of disagreement with the accepted level, and a
  // count of pressed cycles since the press (or since a release glitch ended).
  bit         m_sm1[2], m_sm2[2], m_lvl[2], m_gl[2], m_ld[2];
  bit         m_pr[2], m_rl[2], m_lg[2];
  int         m_run[2], m_hold[2];
  logic [7:0] m_cnt[2];

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_sm1[b] = 0; m_sm2[b] = 0; m_lvl[b] = 0; m_gl[b] = 0; m_ld[b] = 0;
      m_pr[b] = 0; m_rl[b] = 0; m_lg[b] = 0; m_run[b] = 0; m_hold[b] = 0;
      m_cnt[b] = 8'd0;
    end
  endfunction

  function automatic void model_edge();
    bit s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int b = 0; b < 2; b++) begin
      s = m_sm2[b];
      m_sm2[b] = m_sm1[b];
      m_sm1[b] = ~pl_btn[b];
      m_pr[b] = 0; m_rl[b] = 0; m_lg[b] = 0;
      if (s != m_lvl[b]) m_run[b]++; else m_run[b] = 0;
      if (m_lvl[b]) begin
        if (!s) begin
          m_hold[b] = 0; m_gl[b] = 1;
        end else if (m_gl[b]) begin
          m_gl[b] = 0;
        end else begin
          m_hold[b]++;
          if (m_hold[b] == LONG && !m_ld[b]) begin m_lg[b] = 1; m_ld[b] = 1; end
        end
      end
      if (m_run[b] == DB + 1) begin
        m_lvl[b] = !m_lvl[b];
        m_run[b] = 0;
        if (m_lvl[b]) begin
          m_pr[b] = 1; m_cnt[b] = m_cnt[b] + 8'd1;
          m_hold[b] = 0; m_gl[b] = 0; m_ld[b] = 0;
        end else begin
          m_rl[b] = 1;
        end
      end
    end
  endfunction

  function automatic logic [23:0] model_vec();
    return {m_lvl[1], m_lvl[0], m_pr[1], m_pr[0], m_rl[1], m_rl[0],
            m_lg[1], m_lg[0], m_cnt[1], m_cnt[0]};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {btn_level, btn_press, btn_release, btn_long, press_cnt};
  endfunction

  function automatic void check(input string name, input longint unsigned got,
                                input longint unsigned exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model", dut_vec(), model_vec());
  endtask

  typedef struct {
    logic [1:0]  pad;
    int unsigned ticks;
    logic [1:0]  lvl;
    logic [7:0]  c0;
    logic [7:0]  c1;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int first_p, first_l, first_r, np, nl, nr, ev0;

    tbl[0] = '{2'b11,  5, 2'b00, 8'd0, 8'd0};
    tbl[1] = '{2'b10, 20, 2'b01, 8'd1, 8'd0};
    tbl[2] = '{2'b11, 20, 2'b00, 8'd1, 8'd0};
    tbl[3] = '{2'b01,  3, 2'b00, 8'd1, 8'd0};
    tbl[4] = '{2'b11, 10, 2'b00, 8'd1, 8'd0};
    tbl[5] = '{2'b00, 15, 2'b11, 8'd2, 8'd1};
    tbl[6] = '{2'b11,  2, 2'b11, 8'd2, 8'd1};
    tbl[7] = '{2'b00, 40, 2'b11, 8'd2, 8'd1};
    tbl[8] = '{2'b11, 15, 2'b00, 8'd2, 8'd1};

    // Reset with both buttons held: nothing reported.
    pl_btn = 2'b00;
    rst_n  = 1'b0;
    model_reset();
    #12;
    check("reset_vals", dut_vec(), 24'h0);
    tick(); tick();
    pl_btn = 2'b11;
    rst_n  = 1'b1;

    for (int i = 0; i < 9; i++) begin
      pl_btn = tbl[i].pad;
      for (int k = 0; k < int'(tbl[i].ticks); k++) tick();
      check($sformatf("vec%0d_level", i), btn_level, tbl[i].lvl);
      check($sformatf("vec%0d_cnt0", i), press_cnt[7:0], tbl[i].c0);
      check($sformatf("vec%0d_cnt1", i), press_cnt[15:8], tbl[i].c1);
    end

    // Clean press followed by a long hold.
    first_p = -1; first_l = -1; np = 0; nl = 0;
    pl_btn[0] = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (btn_press[0]) begin np++; if (first_p < 0) first_p = k; end
      if (btn_long[0])  begin nl++; if (first_l < 0) first_l = k; end
    end
    check("press_latency", first_p, LAT);
    check("press_pulses", np, 1);
    check("press_cnt0", press_cnt[7:0], 3);
    check("long_delay", first_l - first_p, LONG);
    check("long_pulses", nl, 1);

    // Short release glitch while held.
    nl = 0; nr = 0;
    pl_btn[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); nl += int'(btn_long[0]); nr += int'(btn_release[0]);
    end
    pl_btn[0] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick(); nl += int'(btn_long[0]); nr += int'(btn_release[0]);
    end
    check("glitch_release", nr, 0);
    check("glitch_long", nl, 0);
    check("glitch_level", btn_level[0], 1);

    // Real release.
    first_r = -1; nr = 0;
    pl_btn[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (btn_release[0]) begin nr++; if (first_r < 0) first_r = k; end
    end
    check("release_latency", first_r, LAT);
    check("release_pulses", nr, 1);
    check("release_level", btn_level[0], 0);

    // Bounce: 5 low, 3 high, 5 low, then released.
    np = 0;
    pl_btn[0] = 1'b0; for (int k = 0; k < 5; k++) begin tick(); np += int'(btn_press[0]); end
    pl_btn[0] = 1'b1; for (int k = 0; k < 3; k++) begin tick(); np += int'(btn_press[0]); end
    pl_btn[0] = 1'b0; for (int k = 0; k < 5; k++) begin tick(); np += int'(btn_press[0]); end
    pl_btn[0] = 1'b1; for (int k = 0; k < 15; k++) begin tick(); np += int'(btn_press[0]); end
    check("bounce_press", np, 0);
    check("bounce_level", btn_level[0], 0);
    check("bounce_cnt0", press_cnt[7:0], 3);

    // Reset while held in PRESSED, button kept down across reset release.
    pl_btn[0] = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("pre_reset_level", btn_level[0], 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_async", dut_vec(), 24'h0);
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b1;
    first_p = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (btn_press[0] && first_p < 0) first_p = k;
    end
    check("reset_repress_latency", first_p, LAT);
    check("reset_repress_cnt0", press_cnt[7:0], 1);

    // Counter wrap on btn1 with btn0 idle.
    pl_btn = 2'b11;
    rst_n  = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    np = 0; ev0 = 0;
    for (int p = 0; p < 256; p++) begin
      pl_btn[1] = 1'b0;
      for (int k = 0; k < 12; k++) begin
        tick(); np += int'(btn_press[1]);
        ev0 += int'(btn_press[0] | btn_release[0] | btn_long[0]);
      end
      pl_btn[1] = 1'b1;
      for (int k = 0; k < 12; k++) begin
        tick(); np += int'(btn_press[1]);
        ev0 += int'(btn_press[0] | btn_release[0] | btn_long[0]);
      end
    end
    check("wrap_presses", np, 256);
    check("wrap_cnt1", press_cnt[15:8], 0);
    check("wrap_cnt0", press_cnt[7:0], 0);
    check("wrap_btn0_events", ev0, 0);

    // Random pad activity against the model.
    for (int k = 0; k < 4000; k++) begin
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 15) == 0) pl_btn[b] = ~pl_btn[b];
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
